// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit: forward selects, MDU FSM
// states and the packed pipeline-control vector with its named patterns.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  // Bit order, MSB first: {StallF,FlushF,StallD,FlushD,StallE,FlushE,StallM,FlushM,StallW,FlushW}
  localparam int CTRL_W = 10;
  typedef logic [CTRL_W-1:0] ctrl_t;

  localparam ctrl_t CTRL_RST     = 10'b01_01_01_01_01;
  localparam ctrl_t CTRL_FREEZE  = 10'b10_10_10_10_10;
  localparam ctrl_t CTRL_MISPRED = 10'b00_01_01_00_00;
  localparam ctrl_t CTRL_MDU     = 10'b10_10_10_01_00;
  localparam ctrl_t CTRL_LOADUSE = 10'b10_10_01_00_00;
  localparam ctrl_t CTRL_NONE    = 10'b00_00_00_00_00;

endpackage

// File: rtl/mdu_stall_ctrl.sv
// Holds a multi-cycle MDU op in EX for MDU_LAT un-frozen cycles.
// MduBusy doubles as the FSM state observation point.
module mdu_stall_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MduStartE,
  input  logic freeze,
  input  logic kill,
  output logic mdu_hold,
  output logic MduBusy
);

  localparam int CNT_W = (MDU_LAT > 1) ? $clog2(MDU_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = (MDU_LAT > 1) ? CNT_W'(MDU_LAT - 2) : '0;

  mdu_state_t       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             start_ok;

  // The first EX cycle is already a hold cycle, so the counter loads LAT-2.
  assign start_ok = MduStartE && !kill && !freeze && (MDU_LAT > 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      MDU_IDLE: begin
        if (start_ok) begin
          state_n = MDU_BUSY;
          cnt_n   = CNT_INIT;
        end
      end
      MDU_BUSY: begin
        if (!freeze) begin
          if (cnt != '0) cnt_n = cnt - CNT_W'(1);
          else           state_n = MDU_IDLE;
        end
      end
    endcase
  end

  always_comb begin
    mdu_hold = 1'b0;
    case (state)
      MDU_IDLE: mdu_hold = start_ok;
      MDU_BUSY: mdu_hold = (cnt != '0);
    endcase
    MduBusy = (state == MDU_BUSY);
  end

endmodule

// File: rtl/hazard_unit_mdu.sv
// Hazard/forwarding unit: prioritised stall/flush generation, operand
// forwarding, MDU hold control and stall/mispredict performance counters.
module hazard_unit_mdu
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int MDU_LAT    = 4,
  parameter int PERF_W     = 32
) (
  input  logic                           CpuClk,
  input  logic                           CpuRstN,
  input  logic                           ICacheMiss,
  input  logic                           DCacheMiss,
  input  logic                           BranchE,
  input  logic                           BranchPredictedE,
  input  logic                           MduStartE,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  RsD,
  input  logic [NUM_SRC-1:0]             RegReadD,
  input  logic [NUM_SRC*REG_ADDR_W-1:0]  RsE,
  input  logic [NUM_SRC-1:0]             RegReadE,
  input  logic [REG_ADDR_W-1:0]          RdE,
  input  logic [REG_ADDR_W-1:0]          RdM,
  input  logic [REG_ADDR_W-1:0]          RdW,
  input  logic                           MemToRegE,
  input  logic                           RegWriteM,
  input  logic                           RegWriteW,
  output logic                           StallF,
  output logic                           FlushF,
  output logic                           StallD,
  output logic                           FlushD,
  output logic                           StallE,
  output logic                           FlushE,
  output logic                           StallM,
  output logic                           FlushM,
  output logic                           StallW,
  output logic                           FlushW,
  output logic [2*NUM_SRC-1:0]           ForwardE,
  output logic                           MduBusy,
  output logic [PERF_W-1:0]              StallCnt,
  output logic [PERF_W-1:0]              MispredCnt
);

  logic  cache_miss, mispred, mdu_hold, load_use_hit, load_use;
  ctrl_t ctrl;

  assign cache_miss = ICacheMiss | DCacheMiss;
  assign mispred    = BranchE ^ BranchPredictedE;

  mdu_stall_ctrl #(.MDU_LAT(MDU_LAT)) u_mdu (
    .clk       (CpuClk),
    .rst_n     (CpuRstN),
    .MduStartE (MduStartE),
    .freeze    (cache_miss),
    .kill      (mispred),
    .mdu_hold  (mdu_hold),
    .MduBusy   (MduBusy)
  );

  always_comb begin
    load_use_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RegReadD[i] && (RsD[i*REG_ADDR_W +: REG_ADDR_W] == RdE)) load_use_hit = 1'b1;
    end
    load_use = MemToRegE && (RdE != '0) && load_use_hit;
  end

  always_comb begin
    if (!CpuRstN)        ctrl = CTRL_RST;
    else if (cache_miss) ctrl = CTRL_FREEZE;
    else if (mispred)    ctrl = CTRL_MISPRED;
    else if (mdu_hold)   ctrl = CTRL_MDU;
    else if (load_use)   ctrl = CTRL_LOADUSE;
    else                 ctrl = CTRL_NONE;
  end

  assign {StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW} = ctrl;

  // MEM is checked first so the younger result wins over WB.
  always_comb begin
    ForwardE = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (RegWriteM && RegReadE[i] && (RdM != '0) && (RdM == RsE[i*REG_ADDR_W +: REG_ADDR_W]))
        ForwardE[2*i +: 2] = FWD_MEM;
      else if (RegWriteW && RegReadE[i] && (RdW != '0) && (RdW == RsE[i*REG_ADDR_W +: REG_ADDR_W]))
        ForwardE[2*i +: 2] = FWD_WB;
      else
        ForwardE[2*i +: 2] = FWD_NONE;
    end
  end

  always_ff @(posedge CpuClk) begin
    if (!CpuRstN) begin
      StallCnt   <= '0;
      MispredCnt <= '0;
    end else begin
      if (StallF)                  StallCnt   <= StallCnt + PERF_W'(1);
      if (mispred && !cache_miss)  MispredCnt <= MispredCnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mdu.sv
// Directed bench for hazard_unit_mdu: reset, MDU hold with and without cache
// freezes, load-use, forwarding, mispredicts and mid-operation reset.
module tb_hazard_unit_mdu;

  localparam int AW = 5;
  localparam int NS = 2;
  localparam int PW = 32;

  // {StallF,FlushF,StallD,FlushD,StallE,FlushE,StallM,FlushM,StallW,FlushW}
  localparam logic [9:0] C_RST  = 10'b0101010101;
  localparam logic [9:0] C_FRZ  = 10'b1010101010;
  localparam logic [9:0] C_MIS  = 10'b0001010000;
  localparam logic [9:0] C_MDU  = 10'b1010100100;
  localparam logic [9:0] C_LU   = 10'b1010010000;
  localparam logic [9:0] C_NONE = 10'b0000000000;

  logic clk = 1'b0;
  logic rst_n;
  logic icache_miss, dcache_miss, branch_e, branch_pred_e, mdu_start_e;
  logic [NS*AW-1:0] rs_d, rs_e;
  logic [NS-1:0]    reg_read_d, reg_read_e;
  logic [AW-1:0]    rd_e, rd_m, rd_w;
  logic             mem_to_reg_e, reg_write_m, reg_write_w;
  logic stall_f, flush_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, stall_w, flush_w;
  logic [2*NS-1:0]  forward_e;
  logic             mdu_busy;
  logic [PW-1:0]    stall_cnt, mispred_cnt;
  logic [9:0]       ctrl;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];
  logic [PW-1:0] exp_stall, exp_mispred;

  assign ctrl = {stall_f, flush_f, stall_d, flush_d, stall_e, flush_e, stall_m, flush_m, stall_w, flush_w};

  hazard_unit_mdu #(.REG_ADDR_W(AW), .NUM_SRC(NS), .MDU_LAT(4), .PERF_W(PW)) dut (
    .CpuClk(clk), .CpuRstN(rst_n), .ICacheMiss(icache_miss), .DCacheMiss(dcache_miss),
    .BranchE(branch_e), .BranchPredictedE(branch_pred_e), .MduStartE(mdu_start_e),
    .RsD(rs_d), .RegReadD(reg_read_d), .RsE(rs_e), .RegReadE(reg_read_e),
    .RdE(rd_e), .RdM(rd_m), .RdW(rd_w), .MemToRegE(mem_to_reg_e),
    .RegWriteM(reg_write_m), .RegWriteW(reg_write_w),
    .StallF(stall_f), .FlushF(flush_f), .StallD(stall_d), .FlushD(flush_d),
    .StallE(stall_e), .FlushE(flush_e), .StallM(stall_m), .FlushM(flush_m),
    .StallW(stall_w), .FlushW(flush_w), .ForwardE(forward_e), .MduBusy(mdu_busy),
    .StallCnt(stall_cnt), .MispredCnt(mispred_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    icache_miss = 0; dcache_miss = 0; branch_e = 0; branch_pred_e = 0; mdu_start_e = 0;
    rs_d = '0; reg_read_d = '0; rs_e = '0; reg_read_e = '0;
    rd_e = '0; rd_m = '0; rd_w = '0; mem_to_reg_e = 0; reg_write_m = 0; reg_write_w = 0;
  endtask

  // MDU op held in EX for n cycles; miss_mask selects DCacheMiss cycles.
  task automatic run_mdu(input int n, input logic [7:0] miss_mask);
    logic [10:0] e;
    for (int i = 0; i < n; i++) begin
      mdu_start_e = 1'b1;
      dcache_miss = miss_mask[i];
      @(negedge clk);
      if (exp_q.size() == 0) e = '1;
      else e = exp_q.pop_front();
      check_eq("mdu_seq", {21'd0, mdu_busy, ctrl}, {21'd0, e});
      tick();
    end
    mdu_start_e = 1'b0;
    dcache_miss = 1'b0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;
    exp_stall = '0;
    exp_mispred = '0;

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_eq("rst_ctrl", {22'd0, ctrl}, {22'd0, C_RST});
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_ctrl", {22'd0, ctrl}, {22'd0, C_NONE});
    check_eq("post_rst_busy", {31'd0, mdu_busy}, 32'd0);
    check_eq("post_rst_stallcnt", stall_cnt, 32'd0);
    check_eq("post_rst_mispredcnt", mispred_cnt, 32'd0);
    tick();

    // Plain MDU op: hold cycles 0-2, release on cycle 3
    exp_q.push_back({1'b0, C_MDU});
    exp_q.push_back({1'b1, C_MDU});
    exp_q.push_back({1'b1, C_MDU});
    exp_q.push_back({1'b1, C_NONE});
    run_mdu(4, 8'b0000_0000);
    exp_stall = exp_stall + 3;
    check_eq("mdu1_busy_after", {31'd0, mdu_busy}, 32'd0);
    check_eq("mdu1_stallcnt", stall_cnt, exp_stall);

    // MDU op with a two-cycle D-cache freeze on cycles 1-2
    exp_q.push_back({1'b0, C_MDU});
    exp_q.push_back({1'b1, C_FRZ});
    exp_q.push_back({1'b1, C_FRZ});
    exp_q.push_back({1'b1, C_MDU});
    exp_q.push_back({1'b1, C_MDU});
    exp_q.push_back({1'b1, C_NONE});
    run_mdu(6, 8'b0000_0110);
    exp_stall = exp_stall + 5;
    check_eq("mdu2_busy_after", {31'd0, mdu_busy}, 32'd0);
    check_eq("mdu2_stallcnt", stall_cnt, exp_stall);

    // Load-use on operand 1
    mem_to_reg_e = 1'b1; rd_e = 5'd5; rs_d = {5'd5, 5'd0}; reg_read_d = 2'b10;
    @(negedge clk);
    check_eq("lu_hit", {22'd0, ctrl}, {22'd0, C_LU});
    tick();
    exp_stall = exp_stall + 1;
    reg_read_d = 2'b01;
    @(negedge clk);
    check_eq("lu_unread", {22'd0, ctrl}, {22'd0, C_NONE});
    tick();
    rd_e = 5'd0; rs_d = {5'd0, 5'd0}; reg_read_d = 2'b10;
    @(negedge clk);
    check_eq("lu_rd_zero", {22'd0, ctrl}, {22'd0, C_NONE});
    tick();
    check_eq("lu_stallcnt", stall_cnt, exp_stall);
    drive_idle();

    // Forwarding
    rd_m = 5'd7; rd_w = 5'd7; reg_write_m = 1; reg_write_w = 1;
    rs_e = {5'd7, 5'd7}; reg_read_e = 2'b11;
    #1 check_eq("fwd_mem", {28'd0, forward_e}, 32'b1010);
    reg_write_m = 0;
    #1 check_eq("fwd_wb", {28'd0, forward_e}, 32'b0101);
    reg_write_m = 1; rd_m = 5'd0;
    #1 check_eq("fwd_rdm_zero", {28'd0, forward_e}, 32'b0101);
    rd_m = 5'd7; rs_e = {5'd3, 5'd7};
    #1 check_eq("fwd_mixed", {28'd0, forward_e}, 32'b0010);
    rs_e = {5'd7, 5'd7}; reg_read_e = 2'b01;
    #1 check_eq("fwd_unread", {28'd0, forward_e}, 32'b0010);
    reg_write_m = 0; rd_w = 5'd9;
    #1 check_eq("fwd_none", {28'd0, forward_e}, 32'b0000);
    drive_idle();
    tick();

    // Three separate mispredicts
    for (int i = 0; i < 3; i++) begin
      branch_e = 1'b1;
      @(negedge clk);
      check_eq("mispred_flush", {22'd0, ctrl}, {22'd0, C_MIS});
      tick();
      branch_e = 1'b0;
      tick();
    end
    exp_mispred = exp_mispred + 3;
    check_eq("mispred_cnt3", mispred_cnt, exp_mispred);

    branch_e = 1'b1; branch_pred_e = 1'b1;
    @(negedge clk);
    check_eq("pred_correct", {22'd0, ctrl}, {22'd0, C_NONE});
    tick();
    branch_e = 1'b0;
    @(negedge clk);
    check_eq("pred_not_taken", {22'd0, ctrl}, {22'd0, C_MIS});
    tick();
    exp_mispred = exp_mispred + 1;
    branch_pred_e = 1'b0; branch_e = 1'b1; icache_miss = 1'b1;
    @(negedge clk);
    check_eq("mispred_in_miss", {22'd0, ctrl}, {22'd0, C_FRZ});
    tick();
    exp_stall = exp_stall + 1;
    drive_idle();
    check_eq("miss_mispredcnt", mispred_cnt, exp_mispred);
    check_eq("miss_stallcnt", stall_cnt, exp_stall);

    // Reset in the middle of an MDU op
    mdu_start_e = 1'b1;
    @(negedge clk);
    check_eq("mid_start", {22'd0, ctrl}, {22'd0, C_MDU});
    tick();
    check_eq("mid_busy", {31'd0, mdu_busy}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_ctrl", {22'd0, ctrl}, {22'd0, C_RST});
    tick();
    check_eq("mid_rst_busy", {31'd0, mdu_busy}, 32'd0);
    check_eq("mid_rst_stallcnt", stall_cnt, 32'd0);
    check_eq("mid_rst_mispredcnt", mispred_cnt, 32'd0);
    rst_n = 1'b1;
    mdu_start_e = 1'b0;
    @(negedge clk);
    check_eq("mid_after_ctrl", {22'd0, ctrl}, {22'd0, C_NONE});
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mdu.md
Name: hazard_unit_mdu

Overview:
Parametrised next-generation hazard/forwarding unit for the 5-stage RV32 core. It adds three things to the plain hazard logic:
- a sequential stall controller for a multi-cycle multiply/divide unit (MDU) that occupies EX for MDU_LAT cycles;
- per-operand source-valid gating in decode;
- 32-bit performance counters for stall cycles and branch mispredictions.
It sits beside the pipeline registers and drives all Stall*/Flush* and operand-forward selects.

Parameters:
REG_ADDR_W, 5, register-index width
NUM_SRC, 2, number of source operands per instruction (2 or 3)
MDU_LAT, 4, total EX-stage cycles of an MDU op (>=1; 1 means no stall)
PERF_W, 32, width of the performance counters

Ports:
CpuClk  in  1  core clock
CpuRstN  in  1  synchronous active-low reset
ICacheMiss  in  1  instruction cache miss, pipeline must freeze
DCacheMiss  in  1  data cache miss, pipeline must freeze
BranchE  in  1  branch/jalr actually taken in EX
BranchPredictedE  in  1  BTB prediction carried to EX
MduStartE  in  1  instruction in EX is an MDU op
RsD  in  NUM_SRC*REG_ADDR_W  decode source indices, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
RegReadD  in  NUM_SRC  decode operand i actually read
RsE  in  NUM_SRC*REG_ADDR_W  EX source indices
RegReadE  in  NUM_SRC  EX operand i actually read
RdE, RdM, RdW  in  REG_ADDR_W each  destination indices
MemToRegE  in  1  EX instruction is a load
RegWriteM, RegWriteW  in  1 each  MEM/WB instruction writes the register file
StallF, FlushF, StallD, FlushD, StallE, FlushE, StallM, FlushM, StallW, FlushW  out  1 each  pipeline register controls
ForwardE  out  2*NUM_SRC  forward select for operand i at [2i+1:2i]: 10 = MEM, 01 = WB, 00 = register file
MduBusy  out  1  MDU FSM in BUSY
StallCnt  out  PERF_W  cycles with StallF=1
MispredCnt  out  PERF_W  mispredict events

Behaviour:
- Reset is sampled on the CpuClk rising edge with CpuRstN=0. On reset: FSM goes to IDLE, Cnt=0, StallCnt=0, MispredCnt=0, MduBusy=0.
- While CpuRstN=0, the combinational outputs are all Flush*=1 and all Stall*=0.
- Stall/flush priority, highest first:
  1. reset: as above;
  2. ICacheMiss|DCacheMiss: all Stall*=1, all Flush*=0; MDU counter and FSM frozen;
  3. mispredict (BranchE^BranchPredictedE): FlushD=FlushE=1, everything else 0;
  4. MDU hold (mdu_hold=1): StallF=StallD=StallE=1, FlushM=1;
  5. load-use: StallF=StallD=1, FlushE=1;
  6. otherwise all 0.
- Load-use condition: MemToRegE and RdE!=0 and, for some i, RegReadD[i] and RsD[i]==RdE.
- MDU FSM (states IDLE, BUSY; Cnt is a clog2(MDU_LAT) down-counter):
  - IDLE: if MduStartE and MDU_LAT>1 and no cache miss/mispredict, then mdu_hold=1, Cnt<=MDU_LAT-2, next state BUSY.
  - BUSY, Cnt!=0: mdu_hold=1, Cnt<=Cnt-1.
  - BUSY, Cnt==0: mdu_hold=0 (op leaves EX this cycle), next state IDLE.
  - MduStartE is ignored in BUSY.
  - Net effect: an MDU op spends exactly MDU_LAT cycles in EX, counting cycles without cache-miss freezes.
  - A back-to-back MDU op starts in the cycle after release.
- MduBusy = (state==BUSY).
- Mid-operation reset returns the FSM to IDLE immediately; the hold is abandoned.
- Forwarding, per operand i, combinational:
  - 10 if RegWriteM and RegReadE[i] and RdM!=0 and RdM==RsE[i];
  - else 01 under the same conditions with W (RegWriteW, RdW);
  - else 00.
  - MEM always beats WB.
- Counters:
  - StallCnt increments on each clock where StallF=1 (including cache-miss cycles).
  - MispredCnt increments on each clock where a mispredict is present and no cache miss is active.
  - Both wrap modulo 2^PERF_W and are frozen during reset.

Decomposition:
- Package hazard_pkg: localparams FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; MDU state encoding IDLE/BUSY; the bit order of the 10-bit {StallF..FlushW} control vector plus named constants CTRL_RST, CTRL_FREEZE, CTRL_MISPRED, CTRL_MDU, CTRL_LOADUSE, CTRL_NONE.
- Sub-module mdu_stall_ctrl: the FSM and counter, outputs mdu_hold and MduBusy, inputs MduStartE, freeze, kill.
- The forwarding loop and the counters stay in the top module.

Test Plan:
- Reset held 2 cycles, then released → during reset all Flush*=1 and all Stall*=0; afterwards StallCnt=0, MispredCnt=0, MduBusy=0.
- MDU_LAT=4: MduStartE=1 on cycle 0, no misses → StallF/StallD/StallE=1 and FlushM=1 on cycles 0-2, released on cycle 3; MduBusy=1 on cycles 1-3; StallCnt=3.
- Same MDU op with DCacheMiss=1 on cycle 1 for 2 cycles → all Stall*=1 on cycles 1-2; MDU hold resumes on cycles 3-4, released on cycle 5; StallCnt=5.
- RdE=5, MemToRegE=1, RsD[1]=5, RegReadD=2'b10 → StallF=StallD=FlushE=1. Repeat with RegReadD=2'b01 → no stall. Repeat with RdE=0 → no stall.
- RdM=RdW=7, both RegWrite=1, RsE[0]=7, RsE[1]=7 with RegReadE=2'b11 → ForwardE=4'b1010. With RegWriteM=0 → 4'b0101.
- BranchE=1, BranchPredictedE=0 for 3 separate cycles → FlushD=FlushE=1 each cycle, MispredCnt=3. The same event during ICacheMiss → no flush and MispredCnt unchanged.
